mem_stream_loader: RTL and testbench

//  Upstream feeder for the 4096x32 single-port on-chip program memory. Takes a byte stream
//  (valid/ready, e.g. from a UART RX) and packs 4 bytes little-endian into one word. Writes

---
 rtl/mem_loader_pkg.sv | 29 ++
 rtl/mem_loader_packer.sv | 56 +++++
 rtl/mem_stream_loader.sv | 159 +++++++++++++++
 tb/tb_mem_stream_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared state encoding, constants and byte-enable helper for the memory stream loader.
// LOADER_VERIFY_EN (when defined) enables read-back verification in mem_stream_loader.
package mem_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned NBYTES_W       = 3;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        VERIFY_RD,
        VERIFY_CMP,
        DONE
    } state_t;

    // Low nbytes bits set; nbytes in 1..BYTES_PER_WORD.
    function automatic logic [BYTES_PER_WORD-1:0] byteen_mask(input logic [NBYTES_W-1:0] nbytes);
        logic [BYTES_PER_WORD-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (NBYTES_W'(i) < nbytes) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/mem_loader_packer.sv
// Packs accepted stream bytes little-endian into a word and flags word completion,
// either on a full word or on the final byte of the transfer budget.
module mem_loader_packer
    import mem_loader_pkg::*;
#(
    parameter int unsigned LEN_W = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [LEN_W-1:0]    len,
    input  logic                accept,
    input  logic [7:0]          data,
    output logic [WORD_W-1:0]   word_next_c,
    output logic                word_done_c,
    output logic [NBYTES_W-1:0] nbytes_c,
    output logic                budget_empty_c
);

    logic [LANE_W-1:0] lane;
    logic [WORD_W-1:0] word;
    logic [LEN_W-1:0]  remaining;

    // Word as it looks with the current byte dropped into its lane.
    always_comb begin
        word_next_c                      = word;
        word_next_c[{lane, 3'b000} +: 8] = data;
        word_done_c    = accept && ((lane == LANE_W'(BYTES_PER_WORD - 1)) ||
                                    (remaining == LEN_W'(1)));
        nbytes_c       = NBYTES_W'(lane) + NBYTES_W'(1);
        budget_empty_c = (remaining == '0);
    end

    // A completed word restarts at lane 0 with zeroed unused bytes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane      <= '0;
            word      <= '0;
            remaining <= '0;
        end else if (load) begin
            lane      <= '0;
            word      <= '0;
            remaining <= len;
        end else if (accept) begin
            remaining <= remaining - LEN_W'(1);
            if (word_done_c) begin
                lane <= '0;
                word <= '0;
            end else begin
                lane <= lane + LANE_W'(1);
                word <= word_next_c;
            end
        end
    end

endmodule

// File: rtl/mem_stream_loader.sv
// Loads a byte stream into word memory through its Avalon slave port.
// Define LOADER_VERIFY_EN to add a read-back compare after every word write.
module mem_stream_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned LEN_W  = 14
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LEN_W-1:0]          byte_count,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic [ADDR_W-1:0]         m_address,
    output logic [BYTES_PER_WORD-1:0] m_byteen,
    output logic                      m_cs,
    output logic                      m_write,
    output logic [WORD_W-1:0]         m_wdata,
    input  logic [WORD_W-1:0]         m_rdata,
    output logic                      m_clken,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [ADDR_W:0]           words_wr
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t              state;
    state_t              next_state;
    logic                load_c;
    logic                accept_c;
    logic                mismatch_c;
    logic [ADDR_W-1:0]   word_addr;
    logic [WORD_W-1:0]   word_next_c;
    logic                word_done_c;
    logic [NBYTES_W-1:0] nbytes_c;
    logic                budget_empty_c;

    assign m_clken  = 1'b1;
    assign accept_c = s_valid & s_ready;

    mem_loader_packer #(
        .LEN_W (LEN_W)
    ) u_packer (
        .clk            (clk),
        .reset_n        (reset_n),
        .load           (load_c),
        .len            (byte_count),
        .accept         (accept_c),
        .data           (s_data),
        .word_next_c    (word_next_c),
        .word_done_c    (word_done_c),
        .nbytes_c       (nbytes_c),
        .budget_empty_c (budget_empty_c)
    );

`ifdef LOADER_VERIFY_EN
    logic [WORD_W-1:0] lane_mask;

    // Compare only the lanes that were actually written.
    always_comb begin
        lane_mask = '0;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            lane_mask[8*i +: 8] = {8{m_byteen[i]}};
        end
        mismatch_c = (((m_rdata ^ m_wdata) & lane_mask) != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else if (load_c) begin
            error <= 1'b0;
        end else if ((state == VERIFY_CMP) && mismatch_c) begin
            error <= 1'b1;
        end
    end
`else
    logic rdata_unused;

    assign mismatch_c   = 1'b0;
    assign error        = 1'b0;
    assign rdata_unused = ^m_rdata;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        next_state = state;
        load_c     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c     = 1'b1;
                    next_state = (byte_count == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (word_done_c) next_state = WRITE;
            end
            WRITE: begin
`ifdef LOADER_VERIFY_EN
                next_state = VERIFY_RD;
`else
                next_state = budget_empty_c ? DONE : COLLECT;
`endif
            end
`ifdef LOADER_VERIFY_EN
            VERIFY_RD:  next_state = VERIFY_CMP;
            VERIFY_CMP: next_state = (mismatch_c || budget_empty_c) ? DONE : COLLECT;
`endif
            DONE:       next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Outputs are registered copies decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_ready   <= 1'b0;
            m_cs      <= 1'b0;
            m_write   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            m_byteen  <= '0;
            word_addr <= '0;
            words_wr  <= '0;
        end else begin
            s_ready <= (next_state == COLLECT);
            m_cs    <= (next_state == WRITE) || (next_state == VERIFY_RD);
            m_write <= (next_state == WRITE);
            busy    <= (next_state == COLLECT) || (next_state == WRITE) ||
                       (next_state == VERIFY_RD) || (next_state == VERIFY_CMP);
            done    <= (next_state == DONE);
            if (load_c) begin
                word_addr <= base_addr;
                words_wr  <= '0;
            end
            if ((state == COLLECT) && (next_state == WRITE)) begin
                m_address <= word_addr;
                m_wdata   <= word_next_c;
                m_byteen  <= byteen_mask(nbytes_c);
                word_addr <= word_addr + ADDR_W'(1);
                words_wr  <= words_wr + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_loader.sv
// Randomized bench for mem_stream_loader: a word-memory model plus a transfer-level
// reference that predicts the writes, byte consumption and status of each load.
module tb_mem_stream_loader;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned LEN_W  = 14;
`ifdef LOADER_VERIFY_EN
    localparam int LAT8 = 14;
`else
    localparam int LAT8 = 10;
`endif

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  byte_count = '0;
    logic [7:0]        s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [ADDR_W-1:0] m_address;
    logic [3:0]        m_byteen;
    logic              m_cs;
    logic              m_write;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata = '0;
    logic              m_clken;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_wr;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:4095];
    bit          corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = '0;

    wr_t  got_q[$];
    wr_t  exp_q[$];
    logic [7:0] bytes_q[$];
    int   done_cnt;
    int   overlap_cnt;
    int   exp_consumed;
    bit   exp_err;
    int   res_idx;
    int   res_lat;
    bit   res_done;
    bit   res_busy;

    always #5 clk = ~clk;

    mem_stream_loader #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_addr  (base_addr),
        .byte_count (byte_count),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .m_address  (m_address),
        .m_byteen   (m_byteen),
        .m_cs       (m_cs),
        .m_write    (m_write),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata),
        .m_clken    (m_clken),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .words_wr   (words_wr)
    );

    // Single-port memory: byte-enabled writes, reads return data one cycle later.
    always @(posedge clk) begin
        if (m_cs && m_write) begin
            for (int b = 0; b < 4; b++)
                if (m_byteen[b]) mem[m_address][8*b +: 8] <= m_wdata[8*b +: 8];
        end
        if (m_cs && !m_write)
            m_rdata <= mem[m_address] ^
                       ((corrupt_en && (m_address == corrupt_addr)) ? 32'h0000_0100 : 32'h0);
    end

    always @(negedge clk) begin
        if (m_cs && m_write) got_q.push_back('{m_address, m_wdata, m_byteen});
        if (done) done_cnt++;
        if (s_ready && m_cs) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fill_seq(input logic [7:0] first, input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(first + 8'(i));
    endtask

    task automatic fill_rand(input int n);
        bytes_q.delete();
        for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
    endtask

    // Transfer-level reference: split the byte list into 4-byte little-endian words.
    task automatic model(input logic [11:0] base, input int count);
        exp_q.delete();
        exp_consumed = count;
        exp_err      = 1'b0;
        for (int w = 0; 4 * w < count; w++) begin
            int  n;
            wr_t e;
            n      = ((count - 4 * w) >= 4) ? 4 : (count - 4 * w);
            e.data = '0;
            for (int k = 0; k < n; k++) e.data[8*k +: 8] = bytes_q[4*w+k];
            e.be   = 4'((1 << n) - 1);
            e.addr = 12'(32'(base) + w);
            exp_q.push_back(e);
`ifdef LOADER_VERIFY_EN
            if (corrupt_en && (e.addr == corrupt_addr) && e.be[1]) begin
                exp_err      = 1'b1;
                exp_consumed = 4 * w + n;
                break;
            end
`endif
        end
    endtask

    // Drive one transfer; optionally pulse start mid-run or abort via reset.
    task automatic run_xfer(input logic [11:0] base, input int count, input int gap_pct,
                            input int busy_start_at, input int abort_at);
        int idx;
        idx = 0;
        res_done = 1'b0;
        res_lat  = -1;
        got_q.delete();
        done_cnt    = 0;
        overlap_cnt = 0;
        @(negedge clk);
        start      = 1'b1;
        base_addr  = base;
        byte_count = LEN_W'(count);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = (c == busy_start_at);
            if (start) begin
                base_addr  = 12'h300;
                byte_count = LEN_W'(4);
            end
            if (c == 0) res_busy = busy;
            if (done) begin
                res_done = 1'b1;
                res_lat  = c;
                break;
            end
            if (abort_at >= 0 && idx >= abort_at) begin
                reset_n = 1'b0;
                break;
            end
            if (idx < count && $urandom_range(99) >= gap_pct) begin
                s_valid = 1'b1;
                s_data  = bytes_q[idx];
                if (s_ready) idx++;
            end else begin
                s_valid = 1'b0;
            end
        end
        s_valid = 1'b0;
        start   = 1'b0;
        res_idx = idx;
    endtask

    task automatic check_xfer(input string tag, input int count);
        int n;
        repeat (3) @(negedge clk);
        check({tag, "_done_seen"}, 32'(res_done), 32'd1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_busy_early"}, 32'(res_busy), 32'(count > 0));
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check($sformatf("%s_data%0d", tag, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s_be%0d", tag, i), 32'(got_q[i].be), 32'(exp_q[i].be));
        end
        check({tag, "_words_wr"}, 32'(words_wr), exp_q.size());
        check({tag, "_consumed"}, res_idx, exp_consumed);
        check({tag, "_error"}, 32'(error), 32'(exp_err));
        check({tag, "_idle"}, {29'd0, busy, s_ready, m_cs}, 32'd0);
        check({tag, "_overlap"}, overlap_cnt, 0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"}, {25'd0, s_ready, m_cs, m_write, busy, done, error, m_clken}, 32'd1);
        check({tag, "_addr"}, 32'(m_address), 32'd0);
        check({tag, "_wdata"}, m_wdata, 32'd0);
        check({tag, "_be_cnt"}, {15'd0, m_byteen, words_wr}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        reset_n = 1'b1;

        // Two full words, with an ignored start while busy and no stalls.
        fill_seq(8'h01, 8);
        model(12'h010, 8);
        run_xfer(12'h010, 8, 0, 3, -1);
        check_xfer("t1", 8);
        check("t1_latency", res_lat, LAT8);

        // Partial last word.
        fill_seq(8'hAA, 6);
        model(12'h020, 6);
        run_xfer(12'h020, 6, 30, -1, -1);
        check_xfer("t2", 6);

        // Address wrap at top of memory.
        fill_rand(8);
        model(12'hFFF, 8);
        run_xfer(12'hFFF, 8, 20, -1, -1);
        check_xfer("t3", 8);

        // Zero-length transfer.
        bytes_q.delete();
        model(12'h100, 0);
        run_xfer(12'h100, 0, 0, -1, -1);
        check_xfer("t4", 0);
        check("t4_latency", res_lat, 0);

        // Abort by reset after 5 bytes.
        fill_seq(8'h01, 8);
        run_xfer(12'h010, 8, 0, -1, 5);
        #1;
        check_reset_outs("t5_abort");
        repeat (2) @(negedge clk);
        check("t5_no_done", done_cnt, 0);
        check("t5_writes_before_abort", got_q.size(), 1);
        reset_n = 1'b1;
        model(12'h010, 8);
        run_xfer(12'h010, 8, 10, -1, -1);
        check_xfer("t5_fresh", 8);

        // Read-back corruption at word 0x011.
        fill_seq(8'h01, 12);
        corrupt_en   = 1'b1;
        corrupt_addr = 12'h011;
        model(12'h010, 12);
        run_xfer(12'h010, 12, 0, -1, -1);
        check_xfer("t6", 12);
        corrupt_en = 1'b0;

        // Random transfers; the first also shows error cleared by a new start.
        for (int t = 0; t < 6; t++) begin
            logic [11:0] b;
            int          cnt;
            b   = 12'($urandom_range(4095));
            cnt = $urandom_range(40, 0);
            fill_rand(cnt);
            model(b, cnt);
            run_xfer(b, cnt, 25, ($urandom_range(1) != 0) ? 2 : -1, -1);
            check_xfer($sformatf("rnd%0d", t), cnt);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
